// File: rtl/sync_fifo_wrarb.sv
// Round-robin arbiter sharing one FIFO write port between NREQ packet requesters.
// Latency: grant 1 cycle after a request is seen in IDLE; first beat can be written in that grant cycle.
// Backpressure: fifo_full_i gates accept combinationally; the grant and beat count hold while full.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   req_valid/data/last      per-requester beat stream (requester i data at [i*DW +: DW])
//   req_ready                one-hot (or zero) accept strobe back to the requesters
//   fifo_full_i              FIFO full flag
//   fifo_wenable_o/wdata_o   FIFO write interface
//   gnt_o, busy_o            current owner (one-hot) and BUSY state indication
//   err_o, err_id_o          watchdog release pulse and the index it released
module sync_fifo_wrarb #(
    parameter int NREQ   = 4,
    parameter int IW     = 2,
    parameter int DW     = 32,
    parameter int MAXLEN = 64,
    parameter int LW     = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    req_ready,
    input  logic               fifo_full_i,
    output logic               fifo_wenable_o,
    output logic [DW-1:0]      fifo_wdata_o,
    output logic [NREQ-1:0]    gnt_o,
    output logic               busy_o,
    output logic               err_o,
    output logic [IW-1:0]      err_id_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] gnt_idx_nxt;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] rr_ptr_nxt;
    logic [LW-1:0] beat_cnt;
    logic [LW-1:0] beat_cnt_nxt;
    logic          err_q;
    logic          err_nxt;
    logic [IW-1:0] err_id_q;
    logic [IW-1:0] err_id_nxt;

    logic          any_valid;
    logic [IW-1:0] pick_idx;
    logic          in_busy;
    logic          cur_valid;
    logic          cur_last;
    logic          accept;
    logic          at_max;

    // Round-robin pick: scan rr_ptr, rr_ptr+1, ... modulo NREQ. The loop runs
    // from the farthest offset down so the nearest valid requester is the last
    // one assigned and therefore wins. The sum is one bit wider than an index
    // so the modulo wrap is exact for non-power-of-two NREQ.
    always_comb begin
        logic [IW:0] sum;
        any_valid = 1'b0;
        pick_idx  = '0;
        sum       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            if (req_valid[sum[IW-1:0]]) begin
                any_valid = 1'b1;
                pick_idx  = sum[IW-1:0];
            end
        end
    end

    assign in_busy   = (state == BUSY) && !rst;
    assign cur_valid = req_valid[gnt_idx];
    assign cur_last  = req_last[gnt_idx];
    // Full goes straight into accept so a write is never issued while full.
    assign accept    = in_busy && cur_valid && !fifo_full_i;
    // Current beat is the MAXLEN-th one of this packet.
    assign at_max    = (beat_cnt == LW'(MAXLEN - 1));

    // Outputs are forced to zero during the reset cycle itself, not only after it.
    assign fifo_wenable_o = accept;
    assign req_ready      = accept ? (NREQ'(1) << gnt_idx) : '0;
    assign fifo_wdata_o   = in_busy ? req_data[gnt_idx*DW +: DW] : '0;
    assign gnt_o          = in_busy ? (NREQ'(1) << gnt_idx) : '0;
    assign busy_o         = in_busy;
    assign err_o          = err_q && !rst;
    assign err_id_o       = rst ? '0 : err_id_q;

    always_comb begin
        state_nxt    = state;
        gnt_idx_nxt  = gnt_idx;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        err_nxt      = 1'b0;
        err_id_nxt   = err_id_q;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    gnt_idx_nxt  = pick_idx;
                    beat_cnt_nxt = '0;
                    state_nxt    = BUSY;
                end
            end
            BUSY: begin
                if (accept) begin
                    beat_cnt_nxt = beat_cnt + LW'(1);
                    if (cur_last || at_max) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
                        // Release on the length limit without last is a watchdog event;
                        // last on the final allowed beat is an ordinary packet end.
                        if (!cur_last) begin
                            err_nxt    = 1'b1;
                            err_id_nxt = gnt_idx;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt_idx  <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            err_q    <= 1'b0;
            err_id_q <= '0;
        end else begin
            state    <= state_nxt;
            gnt_idx  <= gnt_idx_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
            err_q    <= err_nxt;
            err_id_q <= err_id_nxt;
        end
    end

endmodule

// File: tb/tb_sync_fifo_wrarb.sv
// Bench for sync_fifo_wrarb: a directed vector table on a 4-requester instance,
// a short wrap sequence on a 3-requester instance, then random traffic on both
// checked against a packet-level reference model.
module tb_sync_fifo_wrarb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: NREQ=4, MAXLEN=4
    logic         rst_a = 1'b1;
    logic [3:0]   vld_a = '0, lst_a = '0;
    logic [127:0] dat_a = '0;
    logic         full_a = 1'b0;
    logic [3:0]   rdy_a, gnt_a;
    logic         wen_a, busy_a, err_a;
    logic [31:0]  wd_a;
    logic [1:0]   eid_a;

    // Instance B: NREQ=3, MAXLEN=5
    logic         rst_b = 1'b1;
    logic [2:0]   vld_b = '0, lst_b = '0;
    logic [95:0]  dat_b = '0;
    logic         full_b = 1'b0;
    logic [2:0]   rdy_b, gnt_b;
    logic         wen_b, busy_b, err_b;
    logic [31:0]  wd_b;
    logic [1:0]   eid_b;

    sync_fifo_wrarb #(.NREQ(4), .IW(2), .DW(32), .MAXLEN(4), .LW(7)) u_a (
        .clk(clk), .rst(rst_a), .req_valid(vld_a), .req_data(dat_a), .req_last(lst_a),
        .req_ready(rdy_a), .fifo_full_i(full_a), .fifo_wenable_o(wen_a), .fifo_wdata_o(wd_a),
        .gnt_o(gnt_a), .busy_o(busy_a), .err_o(err_a), .err_id_o(eid_a)
    );

    sync_fifo_wrarb #(.NREQ(3), .IW(2), .DW(32), .MAXLEN(5), .LW(7)) u_b (
        .clk(clk), .rst(rst_b), .req_valid(vld_b), .req_data(dat_b), .req_last(lst_b),
        .req_ready(rdy_b), .fifo_full_i(full_b), .fifo_wenable_o(wen_b), .fifo_wdata_o(wd_b),
        .gnt_o(gnt_b), .busy_o(busy_b), .err_o(err_b), .err_id_o(eid_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table (instance A) ----------------
    // Requester i sees data d + i*0x100.
    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [3:0]  l;
        logic        f;
        logic [31:0] d;
        logic [3:0]  gnt;
        logic        busy;
        logic        wen;
        logic [31:0] wd;
        logic        err;
        logic [1:0]  eid;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [3:0] v, input logic [3:0] l, input logic f,
                       input logic [31:0] d, input logic [3:0] g, input logic b, input logic w,
                       input logic [31:0] wd, input logic e, input logic [1:0] eid);
        vec_t x;
        x.rst = r; x.v = v; x.l = l; x.f = f; x.d = d;
        x.gnt = g; x.busy = b; x.wen = w; x.wd = wd; x.err = e; x.eid = eid;
        tbl.push_back(x);
    endtask

    // ---------------- reference model (both instances) ----------------
    int          m_busy[2], m_own[2], m_cnt[2], m_ptr[2], m_errp[2], m_eid[2];
    int          nreq_of[2]   = '{4, 3};
    int          maxlen_of[2] = '{4, 5};
    logic        srst[2], sfull[2];
    logic [3:0]  sv[2], sl[2];
    logic [31:0] sd[2][4];

    task automatic model_eval(input int n, output logic [3:0] e_gnt, output logic [3:0] e_rdy,
                              output logic e_busy, output logic e_wen, output logic e_err,
                              output logic [31:0] e_wd, output logic [1:0] e_eid);
        logic [3:0] one;
        one    = 4'b0001;
        e_gnt  = '0; e_rdy = '0; e_busy = 1'b0; e_wen = 1'b0; e_err = 1'b0;
        e_wd   = '0; e_eid = '0;
        if (!srst[n]) begin
            e_err = (m_errp[n] != 0);
            e_eid = 2'(m_eid[n]);
            if (m_busy[n] != 0) begin
                e_busy = 1'b1;
                e_gnt  = one << m_own[n];
                e_wd   = sd[n][m_own[n]];
                if (sv[n][m_own[n]] && !sfull[n]) begin
                    e_wen = 1'b1;
                    e_rdy = e_gnt;
                end
            end
        end
    endtask

    task automatic model_step(input int n, input logic accepted);
        if (srst[n]) begin
            m_busy[n] = 0; m_own[n] = 0; m_cnt[n] = 0; m_ptr[n] = 0; m_errp[n] = 0; m_eid[n] = 0;
        end else begin
            m_errp[n] = 0;
            if (m_busy[n] == 0) begin
                for (int k = 0; k < nreq_of[n]; k++) begin
                    int idx;
                    idx = (m_ptr[n] + k) % nreq_of[n];
                    if (m_busy[n] == 0 && sv[n][idx]) begin
                        m_own[n] = idx; m_busy[n] = 1; m_cnt[n] = 0;
                    end
                end
            end else if (accepted) begin
                m_cnt[n]++;
                if (sl[n][m_own[n]] || m_cnt[n] == maxlen_of[n]) begin
                    if (!sl[n][m_own[n]]) begin
                        m_errp[n] = 1;
                        m_eid[n]  = m_own[n];
                    end
                    m_busy[n] = 0;
                    m_ptr[n]  = (m_own[n] + 1) % nreq_of[n];
                end
            end
        end
    endtask

    task automatic drive_inst(input int n);
        if (n == 0) begin
            rst_a = srst[0]; vld_a = sv[0]; lst_a = sl[0]; full_a = sfull[0];
            for (int i = 0; i < 4; i++) dat_a[i*32 +: 32] = sd[0][i];
        end else begin
            rst_b = srst[1]; vld_b = sv[1][2:0]; lst_b = sl[1][2:0]; full_b = sfull[1];
            for (int i = 0; i < 3; i++) dat_b[i*32 +: 32] = sd[1][i];
        end
    endtask

    initial begin
        logic [3:0]  e_gnt, e_rdy, a_gnt, a_rdy;
        logic        e_busy, e_wen, e_err, a_busy, a_wen, a_err;
        logic [31:0] e_wd, a_wd;
        logic [1:0]  e_eid, a_eid;

        //    rst v     l     f  d        gnt   busy wen wd         err eid
        add(1, 4'hF, 4'h0, 0, 32'h0,   4'h0, 0, 0, 32'h0,   0, 0); // 0 reset with valids up
        add(1, 4'h0, 4'h0, 0, 32'h0,   4'h0, 0, 0, 32'h0,   0, 0); // 1
        add(0, 4'h1, 4'h0, 0, 32'hA0,  4'h0, 0, 0, 32'h0,   0, 0); // 2 req0 seen in IDLE
        add(0, 4'h1, 4'h0, 0, 32'hA0,  4'h1, 1, 1, 32'hA0,  0, 0); // 3 grant + beat 1
        add(0, 4'h1, 4'h0, 0, 32'hA1,  4'h1, 1, 1, 32'hA1,  0, 0); // 4
        add(0, 4'h1, 4'h1, 0, 32'hA2,  4'h1, 1, 1, 32'hA2,  0, 0); // 5 last
        add(0, 4'h0, 4'h0, 0, 32'h0,   4'h0, 0, 0, 32'h0,   0, 0); // 6 IDLE, ptr=1
        add(0, 4'h3, 4'h2, 0, 32'hB0,  4'h0, 0, 0, 32'h0,   0, 0); // 7 req0,req1: req1 wins
        add(0, 4'h3, 4'h2, 0, 32'hB0,  4'h2, 1, 1, 32'h1B0, 0, 0); // 8 1-beat packet
        add(0, 4'h1, 4'h0, 0, 32'hB0,  4'h0, 0, 0, 32'h0,   0, 0); // 9 bubble, ptr=2 -> req0
        add(0, 4'h1, 4'h0, 0, 32'hB0,  4'h1, 1, 1, 32'hB0,  0, 0); // 10
        for (int i = 0; i < 5; i++)
            add(0, 4'h1, 4'h0, 1, 32'hB1, 4'h1, 1, 0, 32'hB1, 0, 0); // 11-15 full held
        add(0, 4'h1, 4'h0, 0, 32'hB1,  4'h1, 1, 1, 32'hB1,  0, 0); // 16 resume
        add(0, 4'h1, 4'h1, 0, 32'hB2,  4'h1, 1, 1, 32'hB2,  0, 0); // 17 last on beat 3
        add(0, 4'h4, 4'h0, 0, 32'hC0,  4'h0, 0, 0, 32'h0,   0, 0); // 18 ptr=1 -> req2
        add(0, 4'h4, 4'h0, 0, 32'hC0,  4'h4, 1, 1, 32'h2C0, 0, 0); // 19
        add(0, 4'h4, 4'h0, 0, 32'hC1,  4'h4, 1, 1, 32'h2C1, 0, 0); // 20
        add(0, 4'h4, 4'h0, 0, 32'hC2,  4'h4, 1, 1, 32'h2C2, 0, 0); // 21
        add(0, 4'h4, 4'h0, 0, 32'hC3,  4'h4, 1, 1, 32'h2C3, 0, 0); // 22 4th beat, forced
        add(0, 4'h4, 4'h0, 0, 32'hC4,  4'h0, 0, 0, 32'h0,   1, 2); // 23 err pulse
        add(0, 4'h4, 4'h0, 0, 32'hC4,  4'h4, 1, 1, 32'h2C4, 0, 2); // 24 req2 re-granted
        add(0, 4'h4, 4'h4, 0, 32'hC5,  4'h4, 1, 1, 32'h2C5, 0, 2); // 25 last
        add(0, 4'h0, 4'h0, 0, 32'h0,   4'h0, 0, 0, 32'h0,   0, 2); // 26 ptr=3
        add(0, 4'h8, 4'h0, 0, 32'hD0,  4'h0, 0, 0, 32'h0,   0, 2); // 27
        add(0, 4'h8, 4'h0, 0, 32'hD0,  4'h8, 1, 1, 32'h3D0, 0, 2); // 28
        add(0, 4'h8, 4'h0, 0, 32'hD1,  4'h8, 1, 1, 32'h3D1, 0, 2); // 29
        add(0, 4'h8, 4'h0, 0, 32'hD2,  4'h8, 1, 1, 32'h3D2, 0, 2); // 30
        add(0, 4'h8, 4'h8, 0, 32'hD3,  4'h8, 1, 1, 32'h3D3, 0, 2); // 31 last on 4th beat
        add(0, 4'h3, 4'h1, 0, 32'hE0,  4'h0, 0, 0, 32'h0,   0, 2); // 32 no err; ptr wrapped to 0
        add(0, 4'h3, 4'h1, 0, 32'hE0,  4'h1, 1, 1, 32'hE0,  0, 2); // 33 req0 over req1
        add(0, 4'h2, 4'h0, 0, 32'hE0,  4'h0, 0, 0, 32'h0,   0, 2); // 34 ptr=1 -> req1
        add(0, 4'h2, 4'h0, 0, 32'hE0,  4'h2, 1, 1, 32'h1E0, 0, 2); // 35
        add(0, 4'h2, 4'h0, 0, 32'hE1,  4'h2, 1, 1, 32'h1E1, 0, 2); // 36
        add(1, 4'h2, 4'h0, 0, 32'hE2,  4'h0, 0, 0, 32'h0,   0, 0); // 37 reset mid-packet
        add(0, 4'h9, 4'h1, 0, 32'h50,  4'h0, 0, 0, 32'h0,   0, 0); // 38 ptr=0 after reset
        add(0, 4'h9, 4'h1, 0, 32'h50,  4'h1, 1, 1, 32'h50,  0, 0); // 39 req0 granted
        add(0, 4'h0, 4'h0, 0, 32'h0,   4'h0, 0, 0, 32'h0,   0, 0); // 40

        foreach (tbl[r]) begin
            @(negedge clk);
            rst_a = tbl[r].rst; vld_a = tbl[r].v; lst_a = tbl[r].l; full_a = tbl[r].f;
            for (int i = 0; i < 4; i++) dat_a[i*32 +: 32] = tbl[r].d + 32'(i * 256);
            #1;
            chk($sformatf("vec%0d.gnt", r),  32'(gnt_a),  32'(tbl[r].gnt));
            chk($sformatf("vec%0d.busy", r), 32'(busy_a), 32'(tbl[r].busy));
            chk($sformatf("vec%0d.wen", r),  32'(wen_a),  32'(tbl[r].wen));
            chk($sformatf("vec%0d.rdy", r),  32'(rdy_a),  32'(tbl[r].wen ? tbl[r].gnt : 4'h0));
            chk($sformatf("vec%0d.wdata", r), wd_a,       tbl[r].wd);
            chk($sformatf("vec%0d.err", r),  32'(err_a),  32'(tbl[r].err));
            chk($sformatf("vec%0d.eid", r),  32'(eid_a),  32'(tbl[r].eid));
        end

        // ---------------- NREQ=3 wrap from index 2 to 0 (instance B) ----------------
        @(negedge clk);
        rst_b = 1'b0; vld_b = 3'b100; lst_b = 3'b100; dat_b[64 +: 32] = 32'h77;
        #1 chk("w3.idle", 32'(busy_b), 32'h0);
        @(negedge clk);
        #1 chk("w3.gnt2", 32'(gnt_b), 32'h4);
        chk("w3.wdata2", wd_b, 32'h77);
        @(negedge clk);
        vld_b = 3'b011; lst_b = 3'b011;
        #1 chk("w3.bubble", 32'(gnt_b), 32'h0);
        @(negedge clk);
        #1 chk("w3.gnt0", 32'(gnt_b), 32'h1);
        chk("w3.rdy0", 32'(rdy_b), 32'h1);

        // ---------------- random traffic vs reference model ----------------
        for (int n = 0; n < 2; n++) begin
            sv[n] = '0; sl[n] = '0;
            for (int i = 0; i < 4; i++) sd[n][i] = '0;
            m_busy[n] = 0; m_own[n] = 0; m_cnt[n] = 0; m_ptr[n] = 0; m_errp[n] = 0; m_eid[n] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int n = 0; n < 2; n++) begin
                srst[n]  = (cyc == 0) || ($urandom_range(0, 299) == 0);
                sfull[n] = ($urandom_range(0, 3) == 0);
                drive_inst(n);
            end
            #1;
            for (int n = 0; n < 2; n++) begin
                model_eval(n, e_gnt, e_rdy, e_busy, e_wen, e_err, e_wd, e_eid);
                if (n == 0) begin
                    a_gnt = gnt_a; a_rdy = rdy_a; a_busy = busy_a; a_wen = wen_a;
                    a_err = err_a; a_wd = wd_a; a_eid = eid_a;
                end else begin
                    a_gnt = {1'b0, gnt_b}; a_rdy = {1'b0, rdy_b}; a_busy = busy_b; a_wen = wen_b;
                    a_err = err_b; a_wd = wd_b; a_eid = eid_b;
                end
                chk($sformatf("rnd%0d.c%0d.gnt", n, cyc),   32'(a_gnt),  32'(e_gnt));
                chk($sformatf("rnd%0d.c%0d.rdy", n, cyc),   32'(a_rdy),  32'(e_rdy));
                chk($sformatf("rnd%0d.c%0d.busy", n, cyc),  32'(a_busy), 32'(e_busy));
                chk($sformatf("rnd%0d.c%0d.wen", n, cyc),   32'(a_wen),  32'(e_wen));
                chk($sformatf("rnd%0d.c%0d.wdata", n, cyc), a_wd,        e_wd);
                chk($sformatf("rnd%0d.c%0d.err", n, cyc),   32'(a_err),  32'(e_err));
                chk($sformatf("rnd%0d.c%0d.eid", n, cyc),   32'(a_eid),  32'(e_eid));
                model_step(n, e_wen);
                // A requester holds valid/data/last until it sees ready, then may change.
                for (int i = 0; i < nreq_of[n]; i++) begin
                    if (!sv[n][i] || e_rdy[i]) begin
                        sv[n][i] = ($urandom_range(0, 2) != 0);
                        sl[n][i] = ($urandom_range(0, 3) == 0);
                        sd[n][i] = $urandom;
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
